// File: rtl/mips_register_file_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_register_file_mp_if
// Brief    : Decode/writeback-side port bundle of the multi-port register file.
// Revision : 1.0 - initial release
// ============================================================================
interface mips_register_file_mp_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int N_READ     = 2
);
   logic                         write_enable;
   logic [ADDR_WIDTH-1:0]        write_reg;
   logic [DATA_WIDTH-1:0]        write_data;
   logic [DATA_WIDTH/8-1:0]      write_byte_enable;
   logic                         reserve_enable;
   logic [ADDR_WIDTH-1:0]        reserve_reg;
   logic [N_READ*ADDR_WIDTH-1:0] read_reg;
   logic [N_READ*DATA_WIDTH-1:0] read_data;
   logic [N_READ-1:0]            read_busy;
   logic [DATA_WIDTH-1:0]        read_data_v0;

   modport master (
      output write_enable, write_reg, write_data, write_byte_enable,
      output reserve_enable, reserve_reg, read_reg,
      input  read_data, read_busy, read_data_v0
   );

   modport slave (
      input  write_enable, write_reg, write_data, write_byte_enable,
      input  reserve_enable, reserve_reg, read_reg,
      output read_data, read_busy, read_data_v0
   );
endinterface
`default_nettype wire

// File: rtl/mips_register_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : mips_register_file_mp
// Brief    : N-read / 1 byte-enabled write register file with load scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module mips_register_file_mp #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int N_READ     = 2,
   parameter int BYPASS     = 1
) (
   input  wire logic                clk,
   input  wire logic                reset,
   mips_register_file_mp_if.slave   rf
);
   localparam int                    c_NREGS  = 1 << ADDR_WIDTH;
   localparam int                    c_NBYTES = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] c_V0_REG = ADDR_WIDTH'(2);

   logic [DATA_WIDTH-1:0]        r_mem [c_NREGS];
   logic [c_NREGS-1:0]           r_busy;

   logic [DATA_WIDTH-1:0]        w_bmask;
   logic [DATA_WIDTH-1:0]        w_merged;
   logic                         w_wr_hit;
   logic                         w_rsv_hit;
   logic [ADDR_WIDTH-1:0]        w_addr;
   logic [N_READ*DATA_WIDTH-1:0] w_rd_data;
   logic [N_READ-1:0]            w_rd_busy;

   always_comb begin
      w_bmask = '0;
      for (int i = 0; i < c_NBYTES; i++) begin
         w_bmask[8*i +: 8] = {8{rf.write_byte_enable[i]}};
      end
   end

   assign w_wr_hit  = rf.write_enable && (rf.write_reg != '0);
   assign w_rsv_hit = rf.reserve_enable && (rf.reserve_reg != '0);
   assign w_merged  = (r_mem[rf.write_reg] & ~w_bmask) | (rf.write_data & w_bmask);

   // Reserve is applied after the write clear so a same-cycle reserve wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < c_NREGS; i++) begin
            r_mem[i] <= '0;
         end
         r_busy <= '0;
      end else begin
         if (w_wr_hit) begin
            r_mem[rf.write_reg]  <= w_merged;
            r_busy[rf.write_reg] <= 1'b0;
         end
         if (w_rsv_hit) begin
            r_busy[rf.reserve_reg] <= 1'b1;
         end
      end
   end

   // Reserve inputs never reach the read side, so a bypassed read shows busy 0.
   always_comb begin
      w_rd_data = '0;
      w_rd_busy = '0;
      w_addr    = '0;
      for (int p = 0; p < N_READ; p++) begin
         w_addr = rf.read_reg[p*ADDR_WIDTH +: ADDR_WIDTH];
         if (w_addr != '0) begin
            if ((BYPASS != 0) && w_wr_hit && !reset && (rf.write_reg == w_addr)) begin
               w_rd_data[p*DATA_WIDTH +: DATA_WIDTH] = w_merged;
               w_rd_busy[p]                          = 1'b0;
            end else begin
               w_rd_data[p*DATA_WIDTH +: DATA_WIDTH] = r_mem[w_addr];
               w_rd_busy[p]                          = r_busy[w_addr];
            end
         end
      end
   end

   assign rf.read_data    = w_rd_data;
   assign rf.read_busy    = w_rd_busy;
   assign rf.read_data_v0 = r_mem[c_V0_REG];

endmodule
`default_nettype wire

// File: tb/tb_mips_register_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_register_file_mp
// Brief    : Directed scoreboard bench driving a BYPASS=1 and a BYPASS=0 copy.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_register_file_mp;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 3;

   typedef struct {
      string       tag;
      int          dut;
      int          port;
      logic [31:0] data;
      logic        busy;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        we = 1'b0, re = 1'b0;
   logic [4:0]  wreg = '0, rreg = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  wbe = '0;
   logic [4:0]  rd [NR];

   logic [31:0] m_mem [32];
   logic        m_busy [32];
   exp_t        q [$];
   int          checks = 0;
   int          errors = 0;

   mips_register_file_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_READ(NR)) if_b1 ();
   mips_register_file_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_READ(NR)) if_b0 ();

   assign if_b1.write_enable = we;    assign if_b0.write_enable = we;
   assign if_b1.write_reg = wreg;     assign if_b0.write_reg = wreg;
   assign if_b1.write_data = wdata;   assign if_b0.write_data = wdata;
   assign if_b1.write_byte_enable = wbe;  assign if_b0.write_byte_enable = wbe;
   assign if_b1.reserve_enable = re;  assign if_b0.reserve_enable = re;
   assign if_b1.reserve_reg = rreg;   assign if_b0.reserve_reg = rreg;
   assign if_b1.read_reg = {rd[2], rd[1], rd[0]};
   assign if_b0.read_reg = {rd[2], rd[1], rd[0]};

   mips_register_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_READ(NR), .BYPASS(1))
      u_dut_b1 (.clk(clk), .reset(rst), .rf(if_b1.slave));
   mips_register_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_READ(NR), .BYPASS(0))
      u_dut_b0 (.clk(clk), .reset(rst), .rf(if_b0.slave));

   always #5 clk = ~clk;

   function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old_v;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
      return r;
   endfunction

   // Reference model of the register file state, updated at each rising edge.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
         end
      end else begin
         if (we && wreg != 0) begin
            m_mem[wreg]  = merge(m_mem[wreg], wdata, wbe);
            m_busy[wreg] = 1'b0;
         end
         if (re && rreg != 0) m_busy[rreg] = 1'b1;
      end
      #1;
   endtask

   task automatic push_all(input string tag);
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         for (int p = 0; p < NR; p++) begin
            e.tag = tag; e.dut = d; e.port = p;
            if (rd[p] == 0) begin
               e.data = '0; e.busy = 1'b0;
            end else if (d == 1 && we && wreg == rd[p]) begin
               e.data = merge(m_mem[rd[p]], wdata, wbe); e.busy = 1'b0;
            end else begin
               e.data = m_mem[rd[p]]; e.busy = m_busy[rd[p]];
            end
            q.push_back(e);
         end
         e.tag = tag; e.dut = d; e.port = NR; e.data = m_mem[2]; e.busy = 1'b0;
         q.push_back(e);
      end
   endtask

   task automatic pop_compare();
      exp_t        e;
      logic [31:0] act_d;
      logic        act_b;
      while (q.size() > 0) begin
         e = q.pop_front();
         if (e.port == NR) begin
            act_d = (e.dut == 1) ? if_b1.read_data_v0 : if_b0.read_data_v0;
            act_b = 1'b0;
         end else begin
            act_d = (e.dut == 1) ? if_b1.read_data[e.port*DW +: DW] : if_b0.read_data[e.port*DW +: DW];
            act_b = (e.dut == 1) ? if_b1.read_busy[e.port] : if_b0.read_busy[e.port];
         end
         checks++;
         assert (act_d === e.data) else begin
            errors++;
            $error("FAIL %s bypass%0d port%0d data=%h expected=%h", e.tag, e.dut, e.port, act_d, e.data);
         end
         if (e.port != NR) begin
            checks++;
            assert (act_b === e.busy) else begin
               errors++;
               $error("FAIL %s_busy bypass%0d port%0d busy=%b expected=%b", e.tag, e.dut, e.port, act_b, e.busy);
            end
         end
      end
   endtask

   task automatic check(input string tag);
      push_all(tag);
      #1;
      pop_compare();
   endtask

   task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
      rd[0] = a0; rd[1] = a1; rd[2] = a2;
   endtask

   task automatic wr(input logic [4:0] r, input logic [31:0] d, input logic [3:0] be);
      we = 1'b1; wreg = r; wdata = d; wbe = be;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         m_mem[i] = 'x; m_busy[i] = 1'bx;
      end
      set_rd(5'd16, 5'd20, 5'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("reset");

      wr(5'd16, 32'd1234567, 4'hF); tick(); we = 1'b0;
      check("single");

      wr(5'd20, 32'd7654321, 4'hF); tick();
      wr(5'd2, 32'hDEADBEEF, 4'hF); tick(); we = 1'b0;
      check("multi_v0");

      wr(5'd5, 32'h11223344, 4'hF); tick();
      wr(5'd5, 32'hAABBCCDD, 4'b0101); tick(); we = 1'b0;
      set_rd(5'd5, 5'd0, 5'd5);
      check("byte_en");
      wr(5'd0, 32'hFFFFFFFF, 4'hF);
      check("reg0_pre");
      tick(); we = 1'b0;
      check("reg0");

      wr(5'd7, 32'h12345678, 4'hF); tick();
      wr(5'd7, 32'h0000CAFE, 4'b0011);
      set_rd(5'd5, 5'd7, 5'd7);
      check("bypass_pre");
      tick(); we = 1'b0;
      check("bypass_post");

      re = 1'b1; rreg = 5'd9;
      set_rd(5'd9, 5'd9, 5'd0);
      check("reserve_pre");
      tick(); re = 1'b0;
      check("reserve");
      re = 1'b1; tick(); re = 1'b0;
      check("reserve_again");
      wr(5'd9, 32'h00000055, 4'hF);
      check("clear_pre");
      tick(); we = 1'b0;
      check("clear");
      re = 1'b1; tick(); re = 1'b0;
      wr(5'd9, 32'hFFFFFFFF, 4'h0); tick(); we = 1'b0;
      check("be_zero");

      wr(5'd9, 32'h00000099, 4'hF); re = 1'b1; rreg = 5'd9;
      set_rd(5'd16, 5'd20, 5'd0);
      tick(); we = 1'b0; re = 1'b0;
      set_rd(5'd9, 5'd16, 5'd20);
      check("wr_and_reserve");
      re = 1'b1; rreg = 5'd0; tick(); re = 1'b0;
      set_rd(5'd0, 5'd9, 5'd0);
      check("reserve_reg0");

      rst = 1'b1; wr(5'd16, 32'hFFFF0000, 4'hF);
      tick(); rst = 1'b0; we = 1'b0;
      set_rd(5'd16, 5'd20, 5'd9);
      check("reset_mid");
      set_rd(5'd9, 5'd2, 5'd5);
      check("reset_mid2");
      wr(5'd9, 32'h0000ABCD, 4'hF); tick(); we = 1'b0;
      check("post_reset_wb");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
